// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-bus master, load align/extend, store byte enables, pipeline stall.
// Ports: ex* from EX/MEM, bus* to memory, stall upstream, mem* to WB; `MISALIGN_TRAP_EN optional.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] exNewPC,
  input  logic [31:0] exInstruction,
  input  logic [31:0] exAluOut,
  input  logic [31:0] exWriteData,
  input  logic [4:0]  exWriteReg,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        stall,
  output logic        memValid,
  output logic [31:0] memNewPC,
  output logic [31:0] memInstruction,
  output logic [31:0] memAluOut,
  output logic [31:0] memMemOut,
  output logic [4:0]  memWriteReg,
  output logic        memExc
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        uns;
  logic        rd;

  logic        mem_op;
  logic        misalign;
  logic        accept;
  logic        timeout;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ldata;

  assign mem_op = inValid && (memRead || memWrite);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      memSize == 2'b00: misalign = 1'b0;
      memSize == 2'b01: misalign = exAluOut[0];
      default:          misalign = |exAluOut[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign accept  = (state == IDLE) && mem_op && !misalign;
  assign stall   = (state == BUS) || accept;
  assign timeout = !busAck && (cnt == TMO_LAST);

  // Reads enable all lanes; the lane is picked on the way back.
  always_comb begin
    be    = 4'hF;
    wdata = exWriteData;
    if (memWrite) begin
      unique case (1'b1)
        memSize == 2'b00: begin
          be    = 4'b0001 << exAluOut[1:0];
          wdata = {4{exWriteData[7:0]}};
        end
        memSize == 2'b01: begin
          be    = exAluOut[1] ? 4'b1100 : 4'b0011;
          wdata = {2{exWriteData[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign lb = busRdata[{lane, 3'b000} +: 8];
  assign lh = busRdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ldata = busRdata;
    unique case (1'b1)
      size == 2'b00: ldata = {{24{lb[7] & ~uns}}, lb};
      size == 2'b01: ldata = {{16{lh[15] & ~uns}}, lh};
      default: ;
    endcase
    if (!rd) ldata = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      lane           <= '0;
      size           <= '0;
      uns            <= 1'b0;
      rd             <= 1'b0;
      busReq         <= 1'b0;
      busWe          <= 1'b0;
      busAddr        <= '0;
      busWdata       <= '0;
      busBe          <= '0;
      memValid       <= 1'b0;
      memNewPC       <= '0;
      memInstruction <= '0;
      memAluOut      <= '0;
      memMemOut      <= '0;
      memWriteReg    <= '0;
      memExc         <= 1'b0;
    end else begin
      memValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inValid) begin
            memNewPC       <= exNewPC;
            memInstruction <= exInstruction;
            memAluOut      <= exAluOut;
            memWriteReg    <= exWriteReg;
            memMemOut      <= '0;
            memExc         <= 1'b0;
            if (accept) begin
              state    <= BUS;
              cnt      <= '0;
              busReq   <= 1'b1;
              busWe    <= memWrite;
              busAddr  <= {exAluOut[31:2], 2'b00};
              busBe    <= be;
              busWdata <= wdata;
              lane     <= exAluOut[1:0];
              size     <= memSize;
              uns      <= memUnsigned;
              rd       <= memRead;
            end else begin
              // Only a trapped misaligned access is a mem op here.
              memValid <= 1'b1;
              memExc   <= mem_op;
            end
          end
        end
        BUS: begin
          if (busAck || timeout) begin
            state     <= IDLE;
            busReq    <= 1'b0;
            busWe     <= 1'b0;
            memValid  <= 1'b1;
            memExc    <= !busAck;
            memMemOut <= busAck ? ldata : '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage.
// Scoreboard of expected WB bundles; bus responder with per-op ack latency.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  memSize = '0;
  logic        memUnsigned = 1'b0;
  logic [31:0] exNewPC = '0;
  logic [31:0] exInstruction = '0;
  logic [31:0] exAluOut = '0;
  logic [31:0] exWriteData = '0;
  logic [4:0]  exWriteReg = '0;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic        busAck = 1'b0;
  logic [31:0] busRdata = '0;
  logic        stall;
  logic        memValid;
  logic [31:0] memNewPC;
  logic [31:0] memInstruction;
  logic [31:0] memAluOut;
  logic [31:0] memMemOut;
  logic [4:0]  memWriteReg;
  logic        memExc;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid),
    .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .memUnsigned(memUnsigned),
    .exNewPC(exNewPC), .exInstruction(exInstruction),
    .exAluOut(exAluOut), .exWriteData(exWriteData),
    .exWriteReg(exWriteReg),
    .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWdata(busWdata), .busBe(busBe),
    .busAck(busAck), .busRdata(busRdata),
    .stall(stall), .memValid(memValid),
    .memNewPC(memNewPC), .memInstruction(memInstruction),
    .memAluOut(memAluOut), .memMemOut(memMemOut),
    .memWriteReg(memWriteReg), .memExc(memExc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] mo;
    logic [4:0]  wr;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic trap_of(input logic [1:0] sz,
                                   input logic [31:0] a);
    logic t;
    t = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'b01) t = a[0];
    else if (sz != 2'b00) t = (a[1:0] != 2'b00);
`endif
    return t;
  endfunction

  function automatic logic [31:0] load_exp(input logic [31:0] rdat,
      input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [7:0]  by;
    logic [15:0] hw;
    case (a[1:0])
      2'd0: by = rdat[7:0];
      2'd1: by = rdat[15:8];
      2'd2: by = rdat[23:16];
      default: by = rdat[31:24];
    endcase
    hw = a[1] ? rdat[31:16] : rdat[15:0];
    if (sz == 2'b00) return u ? {24'h0, by} : {{24{by[7]}}, by};
    if (sz == 2'b01) return u ? {16'h0, hw} : {{16{hw[15]}}, hw};
    return rdat;
  endfunction

  function automatic logic [3:0] be_exp(input logic wr,
      input logic [1:0] sz, input logic [31:0] a);
    if (!wr || sz[1]) return 4'b1111;
    if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    case (a[1:0])
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] wd_exp(input logic [1:0] sz,
                                         input logic [31:0] d);
    if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      check({nm, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({nm, " pc"}, memNewPC, e.pc);
    check({nm, " ins"}, memInstruction, e.ins);
    check({nm, " alu"}, memAluOut, e.alu);
    check({nm, " memout"}, memMemOut, e.mo);
    check({nm, " wreg"}, 32'(memWriteReg), 32'(e.wr));
    check({nm, " exc"}, 32'(memExc), 32'(e.exc));
  endtask

  // lat = busReq cycle in which ack is given (1 = zero-wait), 0 = never.
  task automatic run_op(input string nm, input logic rdn, input logic wrn,
      input logic [1:0] sz, input logic u, input logic [31:0] a,
      input logic [31:0] wd, input logic [31:0] rdat, input int lat,
      input bit late_ack);
    exp_t e;
    logic memop;
    logic tr;
    logic busop;
    logic to;
    int reqc;
    int stc;
    int vc;
    int vat;
    int nreq;
    memop = rdn | wrn;
    tr    = memop && trap_of(sz, a);
    busop = memop && !tr;
    to    = busop && (lat == 0);
    nreq  = busop ? (to ? T : lat) : 0;
    reqc = 0; stc = 0; vc = 0; vat = -1;
    e.pc  = $urandom;
    e.ins = $urandom;
    e.alu = a;
    e.wr  = 5'($urandom_range(31));
    e.exc = tr || to;
    e.mo  = (rdn && busop && !to) ? load_exp(rdat, a, sz, u) : 32'h0;
    @(negedge clk);
    inValid = 1'b1; memRead = rdn; memWrite = wrn;
    memSize = sz; memUnsigned = u;
    exNewPC = e.pc; exInstruction = e.ins; exAluOut = a;
    exWriteData = wd; exWriteReg = e.wr;
    sb.push_back(e);
    #1;
    if (stall) stc++;
    @(negedge clk);
    inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    exNewPC = $urandom; exInstruction = $urandom;
    exAluOut = $urandom; exWriteData = $urandom;
    exWriteReg = 5'($urandom_range(31));
    for (int c = 0; c < 16; c++) begin
      busAck = 1'b0;
      if (memValid) begin
        vc++;
        vat = c;
        pop_cmp(nm);
      end
      if (stall) stc++;
      if (busReq) begin
        reqc++;
        if (reqc == 1) begin
          check({nm, " addr"}, busAddr, {a[31:2], 2'b00});
          check({nm, " we"}, 32'(busWe), 32'(wrn));
          check({nm, " be"}, 32'(busBe), 32'(be_exp(wrn, sz, a)));
          if (wrn) check({nm, " wdata"}, busWdata, wd_exp(sz, wd));
        end
        if (lat != 0 && reqc == lat) begin
          busAck = 1'b1;
          busRdata = rdat;
        end
      end else if (late_ack && c == T + 3) begin
        busAck = 1'b1;
        busRdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    busAck = 1'b0;
    check({nm, " req_cycles"}, 32'(reqc), 32'(nreq));
    check({nm, " stall_cycles"}, 32'(stc), busop ? 32'(1 + nreq) : 32'd0);
    check({nm, " valid_pulses"}, 32'(vc), 32'd1);
    check({nm, " latency"}, 32'(vat), 32'(nreq));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst busReq", 32'(busReq), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst memValid", 32'(memValid), 32'd0);
    check("rst memExc", 32'(memExc), 32'd0);
    check("rst memAluOut", memAluOut, 32'd0);
    check("rst busAddr", busAddr, 32'd0);
    rst_n = 1'b1;

    run_op("alu", 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 32'h0, 1, 1'b0);
    run_op("lb_s", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0,
           32'h80FF_FF11, 3, 1'b0);
    run_op("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_5678,
           32'h0, 1, 1'b0);
    run_op("lw_to", 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0,
           32'h1234_5678, 0, 1'b1);
    run_op("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0,
           32'hCAFE_F00D, 2, 1'b0);
    run_op("lh_u", 1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0,
           32'h8001_1234, 1, 1'b0);
    run_op("lh_s", 1'b1, 1'b0, 2'b01, 1'b0, 32'h40, 32'h0,
           32'h0000_8000, 2, 1'b0);
    run_op("lb_u", 1'b1, 1'b0, 2'b00, 1'b1, 32'h41, 32'h0,
           32'h0000_A500, 1, 1'b0);
    run_op("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56EF,
           32'h0, 2, 1'b0);
    run_op("sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h0102_0304,
           32'h0, 1, 1'b0);
    run_op("lw11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h84, 32'h0,
           32'h89AB_CDEF, 1, 1'b0);
    run_op("lh_mis", 1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0,
           32'h5555_AAAA, 1, 1'b0);
    run_op("sw_mis", 1'b0, 1'b1, 2'b10, 1'b0, 32'h106, 32'h7777_8888,
           32'h0, 3, 1'b0);

    // Reset while a bus cycle is outstanding.
    @(negedge clk);
    inValid = 1'b1; memRead = 1'b1; memSize = 2'b10;
    exAluOut = 32'h200; exNewPC = 32'h55;
    @(negedge clk);
    inValid = 1'b0; memRead = 1'b0;
    @(negedge clk);
    check("mid busReq_before", 32'(busReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid busReq", 32'(busReq), 32'd0);
    check("mid stall", 32'(stall), 32'd0);
    check("mid memValid", 32'(memValid), 32'd0);
    check("mid memNewPC", memNewPC, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h301, 32'h0,
           32'h0000_7F00, 2, 1'b0);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
